// File: rtl/ddr_word_tx.sv
// DDR serial transmitter: frames parallel words as START, MSB-first data pairs and PARITY/stop
// symbols, two bits per clock, for a DDR output register (rise half, fall half).
module ddr_word_tx #(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clock_in,
  input  logic                  resetb,
  input  logic                  pll_locked,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  dout_rise,
  output logic                  dout_fall,
  output logic                  busy
);

  localparam int unsigned BEATS = WORD_WIDTH / 2;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_DISABLED,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY
  } state_t;

  state_t                  state, state_nxt;
  logic                    sync1, lock_sync;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [WORD_WIDTH-1:0]   shreg, shreg_nxt;
  logic                    par, par_nxt;
  logic                    rise_nxt, fall_nxt, busy_nxt;
  logic                    xfer;

  // Two-flop synchronizer for the asynchronous PLL lock indicator
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync1     <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sync1     <= pll_locked;
      lock_sync <= sync1;
    end
  end

  assign ready_out = lock_sync & ((state == S_IDLE) | (state == S_PARITY));
  assign xfer      = valid_in & ready_out;

  // State, payload and registered line symbol
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      state     <= S_DISABLED;
      cnt       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      dout_rise <= 1'b1;
      dout_fall <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      par       <= par_nxt;
      dout_rise <= rise_nxt;
      dout_fall <= fall_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next state plus the symbol that goes on the pins after the coming edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    par_nxt   = par;
    rise_nxt  = 1'b1;
    fall_nxt  = 1'b1;
    busy_nxt  = 1'b0;
    if (!lock_sync) begin
      // Lock loss aborts any frame; the line falls back to idle-high
      state_nxt = S_DISABLED;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_DISABLED: state_nxt = S_IDLE;
        S_IDLE, S_PARITY: begin
          if (xfer) begin
            state_nxt = S_START;
            shreg_nxt = data_in;
            par_nxt   = ^data_in;
            rise_nxt  = 1'b0;
            busy_nxt  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_START: begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
          rise_nxt  = shreg[WORD_WIDTH-1];
          fall_nxt  = shreg[WORD_WIDTH-2];
          shreg_nxt = shreg << 2;
          busy_nxt  = 1'b1;
        end
        S_DATA: begin
          busy_nxt = 1'b1;
          if (cnt == CNT_W'(BEATS - 1)) begin
            state_nxt = S_PARITY;
            cnt_nxt   = '0;
            rise_nxt  = par;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            rise_nxt  = shreg[WORD_WIDTH-1];
            fall_nxt  = shreg[WORD_WIDTH-2];
            shreg_nxt = shreg << 2;
          end
        end
        default: state_nxt = S_DISABLED;
      endcase
    end
  end

endmodule
